// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared constants and helpers for the SPI Mode 0 slave.
//   DEFAULT_DATA_WIDTH : default SPI word length in bits
//   SYNC_STAGES        : flip-flop depth of the pin synchronisers
//   bit_cnt_width()    : width of a counter that must hold 0..data_width
package spi_slave_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int SYNC_STAGES        = 2;

    function automatic int bit_cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: N-stage flip-flop synchroniser with a selectable reset value.
// Ports:
//   clk_i     : destination clock
//   rst_i     : synchronous, active-high reset
//   rst_val_i : value every stage takes during reset
//   d_i       : asynchronous input
//   q_o       : synchronised output (STAGES cycles of latency)
module spi_slave_sync
    import spi_slave_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rst_val_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ff_q <= {STAGES{rst_val_i}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI Mode 0 (CPOL=0, CPHA=0), MSB-first slave, fully synchronous
// to i_clk. SCLK, CS_n and MOSI are oversampled through equal-latency
// synchronisers; i_clk must run at least 4x SCLK.
// Ports:
//   i_clk, i_rst            : system clock, synchronous active-high reset
//   i_sclk, i_cs_n, i_mosi  : asynchronous SPI pins from the master
//   o_miso                  : slave-out data (registered)
//   i_tx_data, i_tx_valid   : word for the next transfer, valid/ready handshake
//   o_tx_ready              : transmit holding register is empty
//   o_busy                  : synchronised chip select is asserted
//   o_rx_data               : last complete received word
//   o_data_valid            : one-cycle strobe when o_rx_data updates
// Handshake: a word is accepted on any rising i_clk edge where
//   i_tx_valid && o_tx_ready; while o_tx_ready is low i_tx_valid is ignored
//   and the holding register is never overwritten.
// Build option: define SPI_SLAVE_MISO_TRISTATE_EN to float o_miso (1'bz)
//   while deselected instead of driving 0.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_data_valid
);

    localparam int CW = bit_cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    // ---------------- synchronisers ----------------
    logic sclk_s, cs_n_s, mosi_s;

    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(i_clk), .rst_i(i_rst), .rst_val_i(1'b0), .d_i(i_sclk), .q_o(sclk_s)
    );
    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_cs_n (
        .clk_i(i_clk), .rst_i(i_rst), .rst_val_i(1'b1), .d_i(i_cs_n), .q_o(cs_n_s)
    );
    spi_slave_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(i_clk), .rst_i(i_rst), .rst_val_i(1'b0), .d_i(i_mosi), .q_o(mosi_s)
    );

    // ---------------- state ----------------
    logic                  sclk_prev_q, sclk_prev_d;
    logic                  cs_n_prev_q, cs_n_prev_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  miso_q, miso_d;
    logic                  busy_q, busy_d;

    // ---------------- edge detection ----------------
    logic sclk_rise, cs_fall, cs_rise;
    logic tx_load;
    logic pending_eff;
    logic [DATA_WIDTH-1:0] hold_eff;
    logic word_done;
    logic shift_load;
    logic [DATA_WIDTH-1:0] rx_word;

    // SCLK edges only count while selected.
    assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_n_s;
    assign cs_fall   = ~cs_n_s & cs_n_prev_q;
    assign cs_rise   = cs_n_s & ~cs_n_prev_q;

    assign tx_load   = i_tx_valid & ~pending_q;

    // The holding-to-shift copy sees this cycle's write, so a load that
    // coincides with CS fall or word completion is used immediately.
    assign pending_eff = pending_q | tx_load;
    assign hold_eff    = tx_load ? i_tx_data : hold_q;

    assign word_done  = sclk_rise && (bit_cnt_q == LAST_BIT);
    assign shift_load = cs_fall | word_done;
    assign rx_word    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        sclk_prev_d  = sclk_s;
        cs_n_prev_d  = cs_n_s;
        hold_d       = hold_q;
        pending_d    = pending_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        bit_cnt_d    = bit_cnt_q;
        rx_data_d    = rx_data_q;
        data_valid_d = 1'b0;

        if (tx_load) begin
            hold_d    = i_tx_data;
            pending_d = 1'b1;
        end

        if (cs_rise) begin
            // Abort: partial word discarded, loaded tx word is lost,
            // a pending holding word is kept for the next transfer.
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_shift_d = '0;
        end else if (sclk_rise) begin
            rx_shift_d = rx_word;
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (word_done) begin
                rx_data_d    = rx_word;
                data_valid_d = 1'b1;
                bit_cnt_d    = '0;
            end
        end

        if (shift_load && !cs_n_s) begin
            tx_shift_d = pending_eff ? hold_eff : '0;
            if (pending_eff) begin
                pending_d = 1'b0;
            end
        end

        // Registered from the next-state shift value so the new bit appears
        // one cycle after the detected edge, ahead of the next rising edge.
        miso_d = cs_n_s ? 1'b0 : tx_shift_d[DATA_WIDTH-1];
        busy_d = ~cs_n_s;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sclk_prev_q  <= 1'b0;
            cs_n_prev_q  <= 1'b1;
            hold_q       <= '0;
            pending_q    <= 1'b0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            data_valid_q <= 1'b0;
            miso_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sclk_prev_q  <= sclk_prev_d;
            cs_n_prev_q  <= cs_n_prev_d;
            hold_q       <= hold_d;
            pending_q    <= pending_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_data_q    <= rx_data_d;
            data_valid_q <= data_valid_d;
            miso_q       <= miso_d;
            busy_q       <= busy_d;
        end
    end

    assign o_tx_ready   = ~pending_q;
    assign o_busy       = busy_q;
    assign o_rx_data    = rx_data_q;
    assign o_data_valid = data_valid_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign o_miso = busy_q ? miso_q : 1'bz;
`else
    assign o_miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as the SPI master.
module tb_spi_slave;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk, cs_n, mosi;
    logic         miso;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic [W-1:0] rx_data;
    logic         data_valid;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_rx_q[$];
    logic [W-1:0] exp_miso_q[$];
    logic [W-1:0] got_miso_q[$];
    logic [W-1:0] last_rx;

    spi_slave #(.DATA_WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_busy(busy), .o_rx_data(rx_data),
        .o_data_valid(data_valid)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Received-word monitor: every strobe must match the next expected word.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                if (exp_rx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_valid actual=%h required=none", rx_data);
                end else begin
                    e = exp_rx_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e));
                end
            end
        end
    end

    // Master-side monitor: bytes clocked out of MISO against expectations.
    initial begin
        logic [W-1:0] e, g;
        forever begin
            @(negedge clk);
            while (got_miso_q.size() > 0) begin
                g = got_miso_q.pop_front();
                if (exp_miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_miso_byte actual=%h required=none", g);
                end else begin
                    e = exp_miso_q.pop_front();
                    check("miso_byte", 32'(g), 32'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [W-1:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_assert();
        @(negedge clk);
        cs_n = 1'b0;
        wait_cycles(6);
    endtask

    task automatic cs_release();
        wait_cycles(4);
        cs_n = 1'b1;
        wait_cycles(5);
    endtask

    // One SCLK period: 3 clk low (MOSI set, MISO sampled at end), 2 clk high.
    task automatic spi_bit(input logic mo, output logic mi);
        mosi = mo;
        wait_cycles(3);
        mi   = miso;
        sclk = 1'b1;
        wait_cycles(2);
        sclk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [W-1:0] mo, input logic [W-1:0] exp_mi);
        logic [W-1:0] got;
        logic b;
        exp_miso_q.push_back(exp_mi);
        exp_rx_q.push_back(mo);
        for (int i = W - 1; i >= 0; i--) begin
            spi_bit(mo[i], b);
            got[i] = b;
        end
        got_miso_q.push_back(got);
        last_rx = mo;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic b;
        logic [W-1:0] m, s;
        int budget;

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0; last_rx = '0;
        wait_cycles(5);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_data_valid", 32'(data_valid), 32'd0);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        check("reset_miso", 32'(miso), 32'(1'bz));
`else
        check("reset_miso", 32'(miso), 32'd0);
`endif
        rst = 1'b0;
        wait_cycles(3);

        // Single word, plus an ignored second load while not ready.
        load_tx(8'h55);
        check("tx_ready_after_load", 32'(tx_ready), 32'd0);
        load_tx(8'hFF);
        cs_assert();
        check("busy_in_transfer", 32'(busy), 32'd1);
        check("tx_ready_after_cs_fall", 32'(tx_ready), 32'd1);
        xfer_byte(8'hA5, 8'h55);
        cs_release();
        check("busy_after_release", 32'(busy), 32'd0);
        check("rx_held_after_release", 32'(rx_data), 32'hA5);

        // Stream of transfers with fresh words each time.
        for (int t = 0; t < 10; t++) begin
            m = W'($urandom_range(0, 255));
            s = W'($urandom_range(0, 255));
            load_tx(s);
            cs_assert();
            xfer_byte(m, s);
            cs_release();
            wait_cycles($urandom_range(5, 20));
        end

        // No load: MISO carries zeros.
        cs_assert();
        xfer_byte(8'h3C, 8'h00);
        cs_release();

        // Two words in one selection, second loaded while busy.
        load_tx(8'h12);
        cs_assert();
        load_tx(8'h34);
        xfer_byte(8'hF0, 8'h12);
        xfer_byte(8'h0F, 8'h34);
        cs_release();
        check("rx_after_two_words", 32'(rx_data), 32'h0F);

        // Abort after 4 SCLKs: no strobe, rx unchanged.
        cs_assert();
        for (int i = 0; i < 4; i++) spi_bit(1'b1, b);
        cs_release();
        check("rx_after_abort", 32'(rx_data), 32'(last_rx));
        check("tx_ready_after_abort", 32'(tx_ready), 32'd1);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
        check("miso_deselected", 32'(miso), 32'(1'bz));
`else
        check("miso_deselected", 32'(miso), 32'd0);
`endif

        // Full transfer after abort.
        load_tx(8'h9E);
        cs_assert();
        xfer_byte(8'h66, 8'h9E);
        cs_release();
        check("rx_after_recovery", 32'(rx_data), 32'h66);

        // Drain scoreboard with a bounded wait.
        budget = 200;
        while ((exp_rx_q.size() != 0 || exp_miso_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_rx_q.size() != 0 || exp_miso_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d_pending required=0", exp_rx_q.size() + exp_miso_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
